pc_fetch_gen: RTL

Parametrised fetch-address generator for the MIPS pipeline, replacing the plain PC register. Holds the fetch PC and presents it to instruction memory over a valid/ready address handshake. Selects the next PC from exception, ERET, branch and sequential sources. Buffers any redirect that arrives while the fetch cannot advance.

---
 rtl/pc_fetch_gen.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen: fetch-address generator for the MIPS front end.
// Holds the fetch PC, drives it to instruction memory over a valid/ready
// handshake, picks the next PC from exception / ERET / branch / sequential
// sources, and buffers a redirect that shows up while fetch cannot advance.
module pc_fetch_gen #(
   parameter int                ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'hbfc00000),
   parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'hbfc00380),
   parameter int                INC          = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              eret,
   input  logic [ADDR_W-1:0] epc,
   input  logic              exc_req,
   input  logic              fetch_ready,
   output logic [ADDR_W-1:0] pc_f,
   output logic              fetch_valid,
   output logic              pc_adel,
   output logic              redirect_pending
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_PEND = 2'd2
   } state_t;

   // Redirect ranks; a larger value beats a smaller one, NONE means no request.
   localparam logic [1:0] PR_NONE = 2'd0;
   localparam logic [1:0] PR_BR   = 2'd1;
   localparam logic [1:0] PR_ERET = 2'd2;
   localparam logic [1:0] PR_EXC  = 2'd3;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
   logic [1:0]        pend_prio_q, pend_prio_d;
   logic              hold_q, hold_d;

   logic [1:0]        live_prio;
   logic [ADDR_W-1:0] live_pc;
   logic              live_wins;
   logic              pend_is_exc;
   logic              fv;
   logic              adv;

   // Pick the highest-ranked redirect requested this cycle.
   always_comb begin
      live_prio = PR_NONE;
      live_pc   = br_target;
      if (exc_req) begin
         live_prio = PR_EXC;
         live_pc   = EXC_VECTOR;
      end else if (eret) begin
         live_prio = PR_ERET;
         live_pc   = epc;
      end else if (br_taken) begin
         live_prio = PR_BR;
         live_pc   = br_target;
      end
   end

   // Pending rank is PR_NONE outside PEND, so a plain compare is enough;
   // on a tie the newer (live) request wins.
   assign live_wins   = (live_prio != PR_NONE) && (live_prio >= pend_prio_q);
   assign pend_is_exc = (state_q == S_PEND) && (pend_prio_q == PR_EXC);

   // An exception (live or buffered) may push through a decode stall; an
   // unaccepted request (hold) keeps presenting the same address.
   assign fv  = (state_q != S_BOOT) & (~stall | hold_q | exc_req | pend_is_exc);
   assign adv = fv & fetch_ready & (~stall | exc_req | pend_is_exc);

   // Next-PC select, pending-buffer update and FSM transitions.
   always_comb begin
      pc_d        = pc_q;
      pend_pc_d   = pend_pc_q;
      pend_prio_d = pend_prio_q;
      state_d     = state_q;
      // hold can only be set while fv=1, so this also keeps it set until
      // the handshake completes.
      hold_d      = fv & ~fetch_ready;

      if (adv) begin
         if (live_wins) begin
            pc_d = live_pc;
         end else if (pend_prio_q != PR_NONE) begin
            pc_d = pend_pc_q;
         end else begin
            pc_d = pc_q + ADDR_W'(INC);
         end
         pend_prio_d = PR_NONE;
         pend_pc_d   = '0;
      end else if (live_wins) begin
         // No advance this cycle (BOOT, hold, stall, memory busy): park it.
         pend_prio_d = live_prio;
         pend_pc_d   = live_pc;
      end

      case (state_q)
         S_BOOT:  state_d = (pend_prio_d != PR_NONE) ? S_PEND : S_RUN;
         S_RUN:   state_d = (pend_prio_d != PR_NONE) ? S_PEND : S_RUN;
         S_PEND:  state_d = (pend_prio_d != PR_NONE) ? S_PEND : S_RUN;
         default: state_d = S_RUN;
      endcase
   end

   // State registers; reset abandons any in-flight request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_BOOT;
         pc_q        <= RESET_VECTOR;
         pend_pc_q   <= '0;
         pend_prio_q <= PR_NONE;
         hold_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_pc_q   <= pend_pc_d;
         pend_prio_q <= pend_prio_d;
         hold_q      <= hold_d;
      end
   end

   assign pc_f             = pc_q;
   assign fetch_valid      = fv;
   assign pc_adel          = |pc_q[1:0];
   assign redirect_pending = (state_q == S_PEND);

endmodule
